// File: rtl/word_byte_writer.sv
// Stores a 16-bit word to byte-wide memory as two consecutive byte writes.
// The mem_ready handshake can stall either byte, and l_h reports which half is on mem_data.
module word_byte_writer #(
  parameter int ADDR_W    = 8,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       word_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              l_h,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       word_r;
  logic [ADDR_W-1:0] addr_r;
  logic              accept_s;

  logic              mem_wr_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [7:0]        mem_data_s;
  logic              l_h_s;
  logic              busy_s;
  logic              done_s;

  // A new request is only taken while no transfer is in flight
  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // State register and capture of the word/address of an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      word_r  <= 16'h0000;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        word_r <= word_in;
        addr_r <= addr_in;
      end else begin
        word_r <= word_r;
        addr_r <= addr_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_FIRST;
        else          state_s = ST_IDLE;
      end
      ST_FIRST: begin
        if (mem_ready) state_s = ST_SECOND;
        else           state_s = ST_FIRST;
      end
      ST_SECOND: begin
        if (mem_ready) state_s = ST_DONE;
        else           state_s = ST_SECOND;
      end
      ST_DONE: begin
        if (accept_s) state_s = ST_FIRST;
        else          state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from state and captured registers only, so a stall holds everything stable
  always_comb begin
    mem_wr_s   = 1'b0;
    mem_addr_s = '0;
    mem_data_s = 8'h00;
    l_h_s      = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mem_wr_s = 1'b0;
      end
      ST_FIRST: begin
        mem_wr_s   = 1'b1;
        busy_s     = 1'b1;
        mem_addr_s = addr_r;
        mem_data_s = LOW_FIRST ? word_r[7:0] : word_r[15:8];
        l_h_s      = LOW_FIRST ? 1'b0 : 1'b1;
      end
      ST_SECOND: begin
        mem_wr_s   = 1'b1;
        busy_s     = 1'b1;
        // Address increment wraps naturally within ADDR_W bits
        mem_addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        mem_data_s = LOW_FIRST ? word_r[15:8] : word_r[7:0];
        l_h_s      = LOW_FIRST ? 1'b1 : 1'b0;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign mem_wr   = mem_wr_s;
  assign mem_addr = mem_addr_s;
  assign mem_data = mem_data_s;
  assign l_h      = l_h_s;
  assign busy     = busy_s;
  assign done     = done_s;

endmodule
